// File: rtl/axi4_globals_pkg.sv
// Shared AXI4 definitions for the slave memory responder.
// Holds the default byte-address width, response and burst encodings, and the
// write/read channel state types.
package axi4_globals_pkg;

  localparam int unsigned ADDRESS_WIDTH = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         rd_state_e;

endpackage

// File: rtl/axi4_slave_burst_addr_gen.sv
// Combinational AXI4 burst address stepper.
// Ports: addr/len/size/burst describe the current beat; next_addr is the
// address of the following beat; illegal flags a burst that must be answered
// with SLVERR (oversized beat, bad WRAP length, reserved burst type).
module axi4_slave_burst_addr_gen
  import axi4_globals_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDRESS_WIDTH,
  parameter int DATA_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic                  illegal
);

  localparam int unsigned BUS_BYTES = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic                  wrap_len_ok;

  always_comb begin
    step        = ADDR_WIDTH'(1) << size;
    wrap_mask   = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    incr_addr   = addr + step;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    next_addr   = incr_addr;
    illegal     = (32'd1 << size) > 32'(BUS_BYTES);
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  next_addr = incr_addr;
      BURST_WRAP: begin
        // A WRAP with an unusable length steps like INCR; it is flagged anyway.
        if (wrap_len_ok) next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
        else             illegal   = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/axi4_slave_mem_responder.sv
// AXI4 slave backed by a MEM_DEPTH x DATA_WIDTH word memory at base address 0.
// One outstanding write (AW -> W beats -> B) and an independent read engine
// (AR -> R beats). Byte strobes honoured; out-of-range beats give DECERR,
// illegal bursts or wlast mismatches give SLVERR; error beats never touch memory
// and error read beats return zero data.
// Ports: aclk/aresetn (sync active-low), AW/W/B write channels, AR/R read channels.
// Optional build macro AXI4_SLAVE_WAIT_STATES_EN adds parameter WAIT_CYCLES,
// delaying awready/arready after entering idle and wready on every beat.
module axi4_slave_mem_responder
  import axi4_globals_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDRESS_WIDTH,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256,
  parameter int ID_WIDTH   = 4
`ifdef AXI4_SLAVE_WAIT_STATES_EN
  ,parameter int WAIT_CYCLES = 2
`endif
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam int unsigned IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >> OFF_W) < ADDR_WIDTH'(MEM_DEPTH);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'(a >> OFF_W);
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Keeps ready low during the reset cycles themselves; idle state alone would raise it.
  logic in_reset;
  always_ff @(posedge aclk) in_reset <= !aresetn;

  // ---------------- write channel ----------------
  wr_state_e             wr_state, wr_state_nx;
  logic [ID_WIDTH-1:0]   wr_id;
  logic [ADDR_WIDTH-1:0] wr_addr, wr_addr_nx;
  logic [7:0]            wr_len, wr_cnt;
  logic [2:0]            wr_size;
  logic [1:0]            wr_burst;
  logic                  wr_illegal, wr_dec, wr_slv;
  logic                  aw_hs, w_hs, wr_last, wr_beat_dec, wr_beat_slv;
  logic                  wr_wait_ok, rd_wait_ok;

  axi4_slave_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_wr_addr_gen (
    .addr(wr_addr), .len(wr_len), .size(wr_size), .burst(wr_burst),
    .next_addr(wr_addr_nx), .illegal(wr_illegal)
  );

  assign aw_hs       = awvalid && awready;
  assign w_hs        = wvalid && wready;
  assign wr_last     = (wr_cnt == wr_len);
  assign wr_beat_dec = !in_range(wr_addr);
  assign wr_beat_slv = wr_illegal || (wlast != wr_last);

  always_ff @(posedge aclk) begin
    if (!aresetn) wr_state <= W_IDLE;
    else          wr_state <= wr_state_nx;
  end

  always_comb begin
    wr_state_nx = wr_state;
    awready     = 1'b0;
    wready      = 1'b0;
    bvalid      = 1'b0;
    case (wr_state)
      W_IDLE: begin
        awready = !in_reset && wr_wait_ok;
        if (awvalid && awready) wr_state_nx = W_DATA;
      end
      W_DATA: begin
        wready = wr_wait_ok;
        if (wvalid && wready && wr_last) wr_state_nx = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) wr_state_nx = W_IDLE;
      end
      default: wr_state_nx = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      bid      <= '0;
      bresp    <= '0;
      wr_id    <= '0;
      wr_addr  <= '0;
      wr_len   <= '0;
      wr_size  <= '0;
      wr_burst <= '0;
      wr_cnt   <= '0;
      wr_dec   <= 1'b0;
      wr_slv   <= 1'b0;
    end else if (aw_hs) begin
      wr_id    <= awid;
      wr_addr  <= awaddr;
      wr_len   <= awlen;
      wr_size  <= awsize;
      wr_burst <= awburst;
      wr_cnt   <= '0;
      wr_dec   <= 1'b0;
      wr_slv   <= 1'b0;
    end else if (w_hs) begin
      wr_addr <= wr_addr_nx;
      wr_cnt  <= wr_cnt + 8'd1;
      wr_dec  <= wr_dec | wr_beat_dec;
      wr_slv  <= wr_slv | wr_beat_slv;
      if (wr_last) begin
        bid   <= wr_id;
        bresp <= (wr_dec || wr_beat_dec) ? RESP_DECERR :
                 (wr_slv || wr_beat_slv) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // Memory is never reset; a beat arriving on a reset edge is dropped.
  always_ff @(posedge aclk) begin
    if (aresetn && w_hs && !wr_beat_dec && !wr_beat_slv) begin
      for (int unsigned k = 0; k < STRB_W; k++) begin
        if (wstrb[k]) mem[word_idx(wr_addr)][k*8 +: 8] <= wdata[k*8 +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  rd_state_e             rd_state, rd_state_nx;
  logic [ADDR_WIDTH-1:0] rd_addr, rd_addr_nx, rd_fetch_addr, rd_gen_addr;
  logic [7:0]            rd_len, rd_cnt, rd_gen_len;
  logic [2:0]            rd_size, rd_gen_size;
  logic [1:0]            rd_burst, rd_gen_burst, rd_fetch_resp;
  logic [DATA_WIDTH-1:0] rd_fetch_data;
  logic                  rd_illegal, ar_hs, r_hs;

  // While idle the generator looks at the incoming AR so beat 0 is classified
  // from the request itself; afterwards it steps the latched burst.
  assign rd_gen_addr  = (rd_state == R_IDLE) ? araddr  : rd_addr;
  assign rd_gen_len   = (rd_state == R_IDLE) ? arlen   : rd_len;
  assign rd_gen_size  = (rd_state == R_IDLE) ? arsize  : rd_size;
  assign rd_gen_burst = (rd_state == R_IDLE) ? arburst : rd_burst;

  axi4_slave_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_rd_addr_gen (
    .addr(rd_gen_addr), .len(rd_gen_len), .size(rd_gen_size), .burst(rd_gen_burst),
    .next_addr(rd_addr_nx), .illegal(rd_illegal)
  );

  assign ar_hs         = arvalid && arready;
  assign r_hs          = rvalid && rready;
  assign rd_fetch_addr = ar_hs ? araddr : rd_addr_nx;
  assign rd_fetch_resp = !in_range(rd_fetch_addr) ? RESP_DECERR :
                         rd_illegal               ? RESP_SLVERR : RESP_OKAY;
  // Combinational read samples memory before a same-edge write lands: old data.
  assign rd_fetch_data = (rd_fetch_resp == RESP_OKAY) ? mem[word_idx(rd_fetch_addr)] : '0;

  always_ff @(posedge aclk) begin
    if (!aresetn) rd_state <= R_IDLE;
    else          rd_state <= rd_state_nx;
  end

  always_comb begin
    rd_state_nx = rd_state;
    arready     = 1'b0;
    rvalid      = 1'b0;
    case (rd_state)
      R_IDLE: begin
        arready = !in_reset && rd_wait_ok;
        if (arvalid && arready) rd_state_nx = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (rready && rlast) rd_state_nx = R_IDLE;
      end
      default: rd_state_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rid      <= '0;
      rdata    <= '0;
      rresp    <= '0;
      rlast    <= 1'b0;
      rd_addr  <= '0;
      rd_len   <= '0;
      rd_size  <= '0;
      rd_burst <= '0;
      rd_cnt   <= '0;
    end else if (ar_hs) begin
      rid      <= arid;
      rd_addr  <= araddr;
      rd_len   <= arlen;
      rd_size  <= arsize;
      rd_burst <= arburst;
      rd_cnt   <= '0;
      rdata    <= rd_fetch_data;
      rresp    <= rd_fetch_resp;
      rlast    <= (arlen == 8'd0);
    end else if (r_hs) begin
      if (rlast) begin
        rlast <= 1'b0;
      end else begin
        rd_addr <= rd_addr_nx;
        rd_cnt  <= rd_cnt + 8'd1;
        rdata   <= rd_fetch_data;
        rresp   <= rd_fetch_resp;
        rlast   <= (rd_cnt + 8'd1 == rd_len);
      end
    end
  end

  // ---------------- optional wait states ----------------
`ifdef AXI4_SLAVE_WAIT_STATES_EN
  logic [15:0] wr_wait_cnt, rd_wait_cnt;

  // Counters restart on every state change and, for writes, on every accepted beat.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_wait_cnt <= '0;
      rd_wait_cnt <= '0;
    end else begin
      if ((wr_state_nx != wr_state) || w_hs) wr_wait_cnt <= '0;
      else if (!wr_wait_ok)                  wr_wait_cnt <= wr_wait_cnt + 16'd1;
      if (rd_state_nx != rd_state)           rd_wait_cnt <= '0;
      else if (!rd_wait_ok)                  rd_wait_cnt <= rd_wait_cnt + 16'd1;
    end
  end

  assign wr_wait_ok = (wr_wait_cnt == 16'(WAIT_CYCLES));
  assign rd_wait_ok = (rd_wait_cnt == 16'(WAIT_CYCLES));
`else
  assign wr_wait_ok = 1'b1;
  assign rd_wait_ok = 1'b1;
`endif

endmodule

// File: tb/tb_axi4_slave_mem_responder.sv
// Self-checking bench for axi4_slave_mem_responder (default build, no wait states).
// Directed scenarios plus randomized bursts, all checked against a behavioural
// memory/burst model kept in this file.
module tb_axi4_slave_mem_responder;
  import axi4_globals_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 256;
  localparam int IW    = 4;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [IW-1:0] awid = '0, arid = '0, bid, rid;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [7:0]    awlen = '0, arlen = '0;
  logic [2:0]    awsize = '0, arsize = '0;
  logic [1:0]    awburst = '0, arburst = '0, bresp, rresp;
  logic          awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready;
  logic          bvalid, bready = 1'b0, arvalid = 1'b0, arready;
  logic          rlast, rvalid, rready = 1'b0;
  logic [DW-1:0] wdata = '0, rdata;
  logic [3:0]    wstrb = '0;

  always #5 aclk = ~aclk;

  axi4_slave_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .ID_WIDTH(IW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] wbuf_data [16];
  logic [3:0]  wbuf_strb [16];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit wrap_len_ok(input int unsigned len);
    return (len == 1) || (len == 3) || (len == 7) || (len == 15);
  endfunction

  function automatic bit burst_illegal(input int unsigned len, input int unsigned size,
                                       input int unsigned burst);
    if ((1 << size) > DW / 8) return 1'b1;
    if (burst == 3) return 1'b1;
    if (burst == 2 && !wrap_len_ok(len)) return 1'b1;
    return 1'b0;
  endfunction

  // Address of beat i, computed directly from the start address.
  function automatic int unsigned beat_addr(input int unsigned a, input int unsigned len,
                                            input int unsigned size, input int unsigned burst,
                                            input int unsigned i);
    int unsigned nbytes, win, base;
    nbytes = 1 << size;
    if (burst == 0) return a;
    if (burst == 2 && wrap_len_ok(len)) begin
      win  = (len + 1) * nbytes;
      base = a - (a % win);
      return base + ((a - base + i * nbytes) % win);
    end
    return a + i * nbytes;
  endfunction

  task automatic wait_cycle();
    @(posedge aclk);
    #1;
  endtask

  task automatic axi_write(input logic [IW-1:0] id, input int unsigned addr, input int unsigned len,
                           input int unsigned size, input int unsigned burst, input int bad_last,
                           input int unsigned bstall);
    int unsigned cyc;
    bit illegal, any_dec, any_slv;
    logic [1:0] exp_resp;
    illegal = burst_illegal(len, size, burst);
    any_dec = 1'b0;
    any_slv = illegal;
    awid = id; awaddr = addr; awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst);
    awvalid = 1'b1;
    cyc = 0;
    while (!awready && cyc < 100) begin wait_cycle(); cyc++; end
    check_eq("awready_wait", awready, 1);
    wait_cycle();
    awvalid = 1'b0;
    check_eq("wready_after_aw", wready, 1);
    for (int unsigned i = 0; i <= len; i++) begin
      int unsigned a, w;
      bit lastv;
      logic [31:0] d;
      a = beat_addr(addr, len, size, burst, i);
      w = a / 4;
      lastv = (i == len);
      if (int'(i) == bad_last) lastv = !lastv;
      d = wbuf_data[i];
      wdata = d; wstrb = wbuf_strb[i]; wlast = lastv; wvalid = 1'b1;
      cyc = 0;
      while (!wready && cyc < 100) begin wait_cycle(); cyc++; end
      check_eq("wready_beat", wready, 1);
      wait_cycle();
      if (w >= DEPTH) any_dec = 1'b1;
      else if (!illegal && lastv == (i == len))
        for (int k = 0; k < 4; k++)
          if (wbuf_strb[i][k]) model_mem[w][k*8 +: 8] = d[k*8 +: 8];
      if (lastv != (i == len)) any_slv = 1'b1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    check_eq("bvalid_latency", bvalid, 1);
    exp_resp = any_dec ? RESP_DECERR : any_slv ? RESP_SLVERR : RESP_OKAY;
    for (int unsigned s = 0; s < bstall; s++) begin
      wait_cycle();
      check_eq("bvalid_hold", bvalid, 1);
    end
    check_eq("bid", bid, id);
    check_eq("bresp", bresp, exp_resp);
    bready = 1'b1;
    wait_cycle();
    bready = 1'b0;
    check_eq("bvalid_clear", bvalid, 0);
  endtask

  // stall_mode: 0 none, 1 random 0..2 cycles per beat, 2 five cycles on beat 1
  task automatic axi_read(input logic [IW-1:0] id, input int unsigned addr, input int unsigned len,
                          input int unsigned size, input int unsigned burst, input int stall_mode);
    int unsigned cyc;
    bit illegal;
    illegal = burst_illegal(len, size, burst);
    arid = id; araddr = addr; arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst);
    arvalid = 1'b1;
    cyc = 0;
    while (!arready && cyc < 100) begin wait_cycle(); cyc++; end
    check_eq("arready_wait", arready, 1);
    rready = 1'b1;
    wait_cycle();
    arvalid = 1'b0;
    for (int unsigned i = 0; i <= len; i++) begin
      int unsigned a, w, n;
      logic [1:0]  eresp;
      logic [31:0] edata;
      a = beat_addr(addr, len, size, burst, i);
      w = a / 4;
      eresp = (w >= DEPTH) ? RESP_DECERR : illegal ? RESP_SLVERR : RESP_OKAY;
      edata = (eresp != RESP_OKAY) ? 32'h0 : model_mem[w];
      n = (stall_mode == 1) ? $urandom_range(0, 2) : (stall_mode == 2 && i == 1) ? 5 : 0;
      check_eq("rvalid_beat", rvalid, 1);
      check_eq("rid", rid, id);
      check_eq("rdata", rdata, edata);
      check_eq("rresp", rresp, eresp);
      check_eq("rlast", rlast, (i == len));
      for (int unsigned s = 0; s < n; s++) begin
        rready = 1'b0;
        wait_cycle();
        check_eq("rvalid_hold", rvalid, 1);
        check_eq("rdata_hold", rdata, edata);
        check_eq("rlast_hold", rlast, (i == len));
      end
      rready = 1'b1;
      wait_cycle();
    end
    rready = 1'b0;
    check_eq("rvalid_end", rvalid, 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned lens [7];
    logic [31:0] old_word, new_word;
    lens = '{0, 1, 2, 3, 7, 15, 5};

    // reset values
    repeat (3) @(posedge aclk);
    #1;
    check_eq("rst_awready", awready, 0); check_eq("rst_wready", wready, 0);
    check_eq("rst_bvalid", bvalid, 0);   check_eq("rst_arready", arready, 0);
    check_eq("rst_rvalid", rvalid, 0);   check_eq("rst_rlast", rlast, 0);
    check_eq("rst_bid", bid, 0);         check_eq("rst_bresp", bresp, 0);
    check_eq("rst_rid", rid, 0);         check_eq("rst_rresp", rresp, 0);
    check_eq("rst_rdata", rdata, 0);
    aresetn = 1'b1;
    wait_cycle();
    check_eq("rel_awready", awready, 1);
    check_eq("rel_arready", arready, 1);

    // fill the whole memory so every word is known
    for (int unsigned b = 0; b < DEPTH / 16; b++) begin
      for (int unsigned i = 0; i < 16; i++) begin wbuf_data[i] = $urandom; wbuf_strb[i] = 4'hF; end
      axi_write(4'(b), b * 64, 15, 2, 1, -1, 0);
    end

    // INCR write 1..4 at 0x10 and read back with the same id
    for (int unsigned i = 0; i < 4; i++) begin wbuf_data[i] = i + 1; wbuf_strb[i] = 4'hF; end
    axi_write(4'd5, 32'h10, 3, 2, 1, -1, 2);
    axi_read(4'd5, 32'h10, 3, 2, 1, 0);

    // WRAP from 0x0C covers 0x0C,0x00,0x04,0x08
    for (int unsigned i = 0; i < 4; i++) begin wbuf_data[i] = 32'hA0 + i; wbuf_strb[i] = 4'hF; end
    axi_write(4'd6, 32'h0C, 3, 2, 2, -1, 0);
    axi_read(4'd6, 32'h00, 3, 2, 1, 0);

    // just beyond the memory
    wbuf_data[0] = 32'hDEAD_BEEF; wbuf_strb[0] = 4'hF;
    axi_write(4'd7, DEPTH * 4, 0, 2, 1, -1, 0);
    axi_read(4'd7, DEPTH * 4, 0, 2, 1, 0);
    axi_read(4'd7, DEPTH * 4 - 8, 3, 2, 1, 0);

    // long rready stall mid-burst and a long bready stall
    axi_read(4'd8, 32'h40, 7, 2, 1, 2);
    for (int unsigned i = 0; i < 2; i++) begin wbuf_data[i] = $urandom; wbuf_strb[i] = 4'h5; end
    axi_write(4'd9, 32'h200, 1, 2, 1, -1, 6);
    axi_read(4'd9, 32'h200, 1, 2, 1, 0);

    // wlast errors, illegal size, illegal wrap length, reserved burst
    for (int unsigned i = 0; i < 4; i++) begin wbuf_data[i] = $urandom; wbuf_strb[i] = 4'hF; end
    axi_write(4'd1, 32'h100, 1, 2, 1, 0, 0);
    axi_write(4'd2, 32'h110, 1, 2, 1, 1, 0);
    axi_write(4'd3, 32'h120, 0, 3, 1, -1, 0);
    axi_write(4'd4, 32'h130, 2, 2, 2, -1, 0);
    axi_write(4'd5, 32'h140, 1, 2, 3, -1, 0);
    axi_read(4'd1, 32'h100, 7, 2, 1, 0);
    axi_read(4'd2, 32'h130, 2, 2, 2, 0);
    axi_read(4'd3, 32'h140, 1, 2, 3, 0);

    // write and read hit the same word on the same edge: read sees old data
    wbuf_data[0] = 32'h0; // unused here
    awid = 4'd1; awaddr = 32'h80; awlen = 8'd0; awsize = 3'd2; awburst = 2'd1; awvalid = 1'b1;
    for (int unsigned c = 0; c < 100 && !awready; c++) wait_cycle();
    check_eq("col_awready", awready, 1);
    wait_cycle();
    awvalid = 1'b0;
    check_eq("col_wready", wready, 1);
    check_eq("col_arready", arready, 1);
    old_word = model_mem[32];
    new_word = ~old_word;
    arid = 4'd2; araddr = 32'h80; arlen = 8'd0; arsize = 3'd2; arburst = 2'd1; arvalid = 1'b1;
    wdata = new_word; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    wait_cycle();
    arvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0;
    model_mem[32] = new_word;
    check_eq("col_rvalid", rvalid, 1);
    check_eq("col_rdata_old", rdata, old_word);
    check_eq("col_rlast", rlast, 1);
    check_eq("col_bvalid", bvalid, 1);
    check_eq("col_bresp", bresp, RESP_OKAY);
    rready = 1'b1; bready = 1'b1;
    wait_cycle();
    rready = 1'b0; bready = 1'b0;
    axi_read(4'd2, 32'h80, 0, 2, 1, 0);

    // reset during beat 2 of a 4-beat write
    awid = 4'd3; awaddr = 32'h40; awlen = 8'd3; awsize = 3'd2; awburst = 2'd1; awvalid = 1'b1;
    for (int unsigned c = 0; c < 100 && !awready; c++) wait_cycle();
    wait_cycle();
    awvalid = 1'b0;
    check_eq("mid_wready", wready, 1);
    wdata = 32'h1234_5678; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
    wait_cycle();
    model_mem[16] = 32'h1234_5678;
    wdata = 32'h9ABC_DEF0;
    aresetn = 1'b0;
    wait_cycle();
    wvalid = 1'b0;
    check_eq("mid_awready", awready, 0); check_eq("mid_wready0", wready, 0);
    check_eq("mid_bvalid", bvalid, 0);   check_eq("mid_arready", arready, 0);
    check_eq("mid_rvalid", rvalid, 0);   check_eq("mid_bid", bid, 0);
    check_eq("mid_bresp", bresp, 0);     check_eq("mid_rdata", rdata, 0);
    aresetn = 1'b1;
    wait_cycle();
    check_eq("mid_rel_awready", awready, 1);
    axi_read(4'd3, 32'h40, 3, 2, 1, 0);

    // randomized traffic
    for (int unsigned t = 0; t < 40; t++) begin
      int unsigned addr, len, size, burst, r, bad;
      addr  = $urandom_range(0, DEPTH * 4 + 32);
      len   = lens[$urandom_range(0, 6)];
      size  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : 2;
      r     = $urandom_range(0, 9);
      burst = (r == 0) ? 3 : (r < 3) ? 0 : (r < 6) ? 2 : 1;
      bad   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len) : 32'hFFFF_FFFF;
      for (int unsigned i = 0; i < 16; i++) begin
        wbuf_data[i] = $urandom;
        wbuf_strb[i] = 4'($urandom_range(0, 15));
      end
      axi_write(4'($urandom), addr, len, size, burst, int'(bad), $urandom_range(0, 3));
      addr  = $urandom_range(0, DEPTH * 4 + 32);
      len   = lens[$urandom_range(0, 6)];
      size  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : 2;
      burst = $urandom_range(0, 3);
      axi_read(4'($urandom), addr, len, size, burst, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi4_slave_mem_responder.md
AXI4_SLAVE_MEM_RESPONDER -- requirements
Module: axi4_slave_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default ADDRESS_WIDTH (from axi4_globals_pkg), the byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, the data bus width; legal values are 32/64/128/256.
REQ-003 SHALL have parameter MEM_DEPTH, default 256, the number of DATA_WIDTH words; the base address is 0.
REQ-004 SHALL have parameter ID_WIDTH, default 4, the transaction ID width.
REQ-005 Clock/reset: aclk in 1 (all logic on rising edge); aresetn in 1 (synchronous, active-low).
REQ-006 AW ports: awid in ID_WIDTH; awaddr in ADDR_WIDTH; awlen in 8; awsize in 3; awburst in 2; awvalid in 1; awready out 1.
REQ-007 W ports: wdata in DATA_WIDTH; wstrb in DATA_WIDTH/8; wlast in 1; wvalid in 1; wready out 1.
REQ-008 B ports: bid out ID_WIDTH; bresp out 2; bvalid out 1; bready in 1.
REQ-009 AR ports: arid in ID_WIDTH; araddr in ADDR_WIDTH; arlen in 8; arsize in 3; arburst in 2; arvalid in 1; arready out 1.
REQ-010 R ports: rid out ID_WIDTH; rdata out DATA_WIDTH; rresp out 2; rlast out 1; rvalid out 1; rready in 1.

Function
REQ-011 Write FSM SHALL have states W_IDLE (awready=1), W_DATA (wready=1) and W_RESP (bvalid=1), and SHALL accept one outstanding write.
REQ-012 AW handshake in cycle N SHALL latch awid/addr/len/size/burst and move to W_DATA, with wready=1 from cycle N+1.
REQ-013 Each W handshake SHALL write only bytes with wstrb[k]=1 to word addr>>log2(DATA_WIDTH/8), then advance the address.
REQ-014 After beat awlen+1 is accepted in cycle M, bvalid SHALL be 1 in cycle M+1 with bid=latched awid, and SHALL be held until bready.
REQ-015 bresp SHALL be OKAY(00), except: SLVERR(10) if wlast mismatches the final beat or on an illegal size/wrap; DECERR(11) if any beat address is ≥ MEM_DEPTH words. Memory writes SHALL be suppressed for error beats.
REQ-016 Read FSM SHALL have states R_IDLE (arready=1) and R_DATA, and SHALL be independent of the write FSM.
REQ-017 AR handshake in cycle N SHALL give rvalid=1 in cycle N+1 with first-beat data; each R handshake SHALL present the next beat in the next cycle with no bubbles.
REQ-018 rid/rdata/rresp/rlast SHALL be held stable while rvalid=1 and rready=0; rlast SHALL be 1 only on beat arlen.
REQ-019 DECERR/SLVERR read beats SHALL return rdata=0.
REQ-020 Address generation: FIXED keeps the address; INCR adds 2^size; WRAP adds 2^size within a (len+1)*2^size aligned window.
REQ-021 WRAP with len ∉ {1,3,7,15}, or a size with 2^size > DATA_WIDTH/8, SHALL be illegal and yield SLVERR.
REQ-022 Reserved burst 2'b11 SHALL be treated as INCR with SLVERR.
REQ-023 When write and read target the same word in the same cycle, the read SHALL return the old data.
REQ-024 awlen=0 and arlen=0 (single beat) SHALL follow the same latencies, with rlast=1 on the only beat.

Reset
REQ-025 With aresetn=0 at a rising edge: awready, wready, bvalid, arready, rvalid, rlast =0; bid, bresp, rid, rresp, rdata =0; FSMs go to idle.
REQ-026 awready and arready SHALL rise in the first cycle after aresetn returns high.
REQ-027 Reset mid-burst SHALL abort the burst without a response; memory contents SHALL be preserved.

Configuration
REQ-028 Macro AXI4_SLAVE_WAIT_STATES_EN: when defined, parameter WAIT_CYCLES (default 2) SHALL delay awready/arready assertion by WAIT_CYCLES cycles after entering idle, and each wready by WAIT_CYCLES cycles per beat.
REQ-029 When the macro is undefined, WAIT_CYCLES SHALL not exist and the latencies of REQ-012/014/017 apply exactly.

Structure
REQ-030 axi4_globals_pkg SHALL hold the resp encodings (OKAY/EXOKAY/SLVERR/DECERR), burst encodings (FIXED/INCR/WRAP) and the write/read state enums.
REQ-031 Address stepping SHALL live in sub-module axi4_slave_burst_addr_gen (combinational next address plus illegal flag), instantiated once for writes and once for reads.

Verification
REQ-032 Write INCR awaddr=0x10, awlen=3, size=2, data 1..4, wstrb=F, then read back -> bresp=00; rdata 1,2,3,4; rlast on the 4th beat; rid=awid.
REQ-033 Write WRAP awaddr=0x0C, len=3, size=2 -> words at 0x0C, 0x00, 0x04, 0x08 written; bresp=00.
REQ-034 Write awaddr=MEM_DEPTH*4, len=0 -> bresp=11, memory unchanged; read at the same address -> rresp=11, rdata=0.
REQ-035 Hold rready=0 for 5 cycles mid-burst -> rdata/rlast stable; no beat lost; bready low -> bvalid held.
REQ-036 Assert aresetn=0 during beat 2 of a 4-beat write -> all outputs 0 next cycle, awready=1 after release, prior data intact.
